// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its clients: VGA scan-out, two write
// requesters and the single-port video memory.
interface vram_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 24
);
  logic          vga_valid;
  logic [9:0]    h_addr;
  logic [8:0]    v_addr;
  logic [DW-1:0] vga_data;

  logic          wr0_valid;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr0_ready;

  logic          wr1_valid;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          wr1_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vga_valid, h_addr, v_addr,
    output vga_data,
    input  wr0_valid, wr0_addr, wr0_data,
    output wr0_ready,
    input  wr1_valid, wr1_addr, wr1_data,
    output wr1_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_valid, h_addr, v_addr,
    input  vga_data,
    output wr0_valid, wr0_addr, wr0_data,
    input  wr0_ready,
    output wr1_valid, wr1_addr, wr1_data,
    input  wr1_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads take priority, two writers share blanking
// cycles round-robin, and a writer starved for STARVE_LIMIT cycles steals one read slot.
module vram_arbiter #(
  parameter int AW           = 19,
  parameter int DW           = 24,
  parameter int STARVE_LIMIT = 800,
  parameter int CW           = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vram_arbiter_if.slave bus,
  output logic [CW-1:0] steal_cnt_o
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE,
    ACC_STEAL
  } acc_e;

  acc_e          acc;
  logic          anyReq;
  logic          starve;
  logic          gnt1;
  logic          isWrite;
  logic [DW-1:0] vgaData;

  logic [WW-1:0] waitCnt_q, waitCnt_d;
  logic [CW-1:0] stealCnt_q, stealCnt_d;
  logic          lastGrant_q, lastGrant_d;
  logic          rdPend_q, rdPend_d;
  logic          prevSteal_q, prevSteal_d;
  logic [DW-1:0] holdPix_q, holdPix_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waitCnt_q   <= '0;
      stealCnt_q  <= '0;
      lastGrant_q <= 1'b1;
      rdPend_q    <= 1'b0;
      prevSteal_q <= 1'b0;
      holdPix_q   <= '0;
    end else begin
      waitCnt_q   <= waitCnt_d;
      stealCnt_q  <= stealCnt_d;
      lastGrant_q <= lastGrant_d;
      rdPend_q    <= rdPend_d;
      prevSteal_q <= prevSteal_d;
      holdPix_q   <= holdPix_d;
    end
  end

  // A starved counter with no writer left pending must not block scan-out, so reads
  // only yield when starvation coincides with an actual pending write.
  always_comb begin
    anyReq = bus.wr0_valid | bus.wr1_valid;
    starve = (waitCnt_q >= WW'(STARVE_LIMIT));
    gnt1   = bus.wr1_valid & (~bus.wr0_valid | ~lastGrant_q);

    acc = ACC_NONE;
    if (!rst_ni) begin
      acc = ACC_NONE;
    end else if (bus.vga_valid && !(starve && anyReq)) begin
      acc = ACC_READ;
    end else if (anyReq) begin
      acc = bus.vga_valid ? ACC_STEAL : ACC_WRITE;
    end
    isWrite = (acc == ACC_WRITE) || (acc == ACC_STEAL);

    waitCnt_d = waitCnt_q;
    if (isWrite) begin
      waitCnt_d = '0;
    end else if (anyReq && !starve) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end

    lastGrant_d = isWrite ? gnt1 : lastGrant_q;

    stealCnt_d = stealCnt_q;
    if (acc == ACC_STEAL && stealCnt_q != '1) begin
      stealCnt_d = stealCnt_q + 1'b1;
    end

    rdPend_d    = (acc == ACC_READ);
    prevSteal_d = (acc == ACC_STEAL);
    holdPix_d   = vgaData;
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wr0_ready = 1'b0;
    bus.wr1_ready = 1'b0;

    unique case (acc)
      ACC_READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = AW'({bus.h_addr, bus.v_addr});
      end
      ACC_WRITE, ACC_STEAL: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = gnt1 ? bus.wr1_addr : bus.wr0_addr;
        bus.mem_wdata = gnt1 ? bus.wr1_data : bus.wr0_data;
        bus.wr0_ready = ~gnt1;
        bus.wr1_ready = gnt1;
      end
      default: ;
    endcase

    // A stolen slot has no fresh pixel, so scan-out repeats the last one shown.
    if (rdPend_q) begin
      vgaData = bus.mem_rdata;
    end else if (prevSteal_q) begin
      vgaData = holdPix_q;
    end else begin
      vgaData = '0;
    end
    bus.vga_data = vgaData;
    steal_cnt_o  = stealCnt_q;
  end

endmodule
